// File: rtl/counter_ctrl_pkg.sv
// Shared types for the run/pause/single-step counter sequencer.
package counter_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      CLEAR = 3'd3,
      DONE  = 3'd4
   } ctrl_state_t;

   // Prescaler counter width; a 1-bit counter is kept even when PRESCALE is 1.
   function automatic int pre_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between user controls, the sequencer and the counter datapath.
interface counter_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             stop;
   logic             single;
   logic             clear;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             step;
   logic             cnt_clr;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, single, clear, limit, count,
      input  step, cnt_clr, busy, done
   );

   modport slave (
      input  start, stop, single, clear, limit, count,
      output step, cnt_clr, busy, done
   );
endinterface

// File: rtl/counter_ctrl_tick_gen.sv
// Step prescaler: free-runs 0..PRESCALE-1 while enabled, holds otherwise.
// tick is a same-cycle decode of the registered phase; no backpressure.
module tick_gen
   import counter_ctrl_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);
   localparam int PW = pre_width(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;

   always_comb begin
      pre_d = pre_q;
      if (restart) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick = en && (pre_q == PRE_LAST);
endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/single-step sequencer driving the step counter; state changes one edge after a command.
// step is combinational from state, prescaler phase, count and single; busy/done/cnt_clr are registered-state decodes.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic         clk,
   input  logic         rst,
   counter_ctrl_if.slave bus
);
   ctrl_state_t      state_q, state_d;
   logic             single_q;
   logic [WIDTH-1:0] count_w, limit_w;
   logic             at_limit, single_ok, tick, restart, step_c;

   assign count_w  = bus.count;
   assign limit_w  = bus.limit;
   assign at_limit = (count_w == limit_w);
   // A single-step only fires when no higher-priority command is present.
   assign single_ok = bus.single && !single_q && !at_limit
                      && !bus.clear && !bus.stop && !bus.start;

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (state_q == RUN),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      step_c  = 1'b0;
      restart = 1'b0;
      case (state_q)
         IDLE: begin
            step_c = single_ok;
            if (bus.clear) begin
               state_d = CLEAR;
            end else if (bus.start) begin
               state_d = RUN;
               restart = 1'b1;
            end
         end
         RUN: begin
            step_c = tick && !at_limit;
            if (bus.clear) begin
               state_d = CLEAR;
            end else if (bus.stop) begin
               state_d = PAUSE;
            end else if (at_limit) begin
               state_d = DONE;
            end
         end
         PAUSE: begin
            step_c = single_ok;
            if (bus.clear) begin
               state_d = CLEAR;
            end else if (bus.start) begin
               state_d = RUN;
            end
         end
         CLEAR: state_d = IDLE;
         DONE: begin
            if (bus.clear) begin
               state_d = CLEAR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         single_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         single_q <= bus.single;
      end
   end

   assign bus.step    = step_c;
   assign bus.cnt_clr = (state_q == CLEAR);
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural 8-bit counter closing the count loop.
module tb_counter_ctrl;
   localparam int W = 8;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ld;
   logic [W-1:0] ld_val;
   logic [W-1:0] cnt;
   int           n_chk  = 0;
   int           n_fail = 0;
   int           pulses;
   logic [31:0]  seen;

   always #5 clk = ~clk;

   counter_ctrl_if #(.WIDTH(W)) bus ();

   counter_ctrl #(
      .WIDTH    (W),
      .PRESCALE (P)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural counter datapath, with a bench-side load for preset values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (ld)          cnt <= ld_val;
      else if (bus.cnt_clr) cnt <= '0;
      else if (bus.step)    cnt <= cnt + 1'b1;
   end
   assign bus.count = cnt;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc_begin();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_sample();
      @(negedge clk);
   endtask

   task automatic cmd_none();
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.single = 1'b0;
      bus.clear  = 1'b0;
      ld         = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_none();
      bus.limit = 8'd5;
      ld_val    = '0;

      @(negedge clk);
      check("rst_step", bus.step, 0);
      check("rst_cnt_clr", bus.cnt_clr, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      @(negedge clk);
      rst = 1'b0;

      pulses = 0;
      repeat (20) begin
         cyc_begin(); cmd_none(); cyc_sample();
         pulses += int'(bus.step);
      end
      check("idle_steps", pulses, 0);

      // Run from 0 to limit 5; cycle 0 is the first RUN cycle.
      cyc_begin(); bus.limit = 8'd5; bus.start = 1'b1;
      seen = '0; pulses = 0;
      for (int c = 0; c < 26; c++) begin
         cyc_begin(); cmd_none(); cyc_sample();
         if (bus.step) begin seen[c] = 1'b1; pulses++; end
         if (c == 20) begin
            check("run_count20", cnt, 5);
            check("run_busy20", bus.busy, 1);
            check("run_done20", bus.done, 0);
         end
         if (c == 21) begin
            check("run_done21", bus.done, 1);
            check("run_busy21", bus.busy, 0);
         end
      end
      check("run_step_cycles", seen, 32'h0008_8888);
      check("run_pulses", pulses, 5);

      cyc_begin(); bus.start = 1'b1; bus.stop = 1'b1; bus.single = 1'b1; cyc_sample();
      check("done_single_step", bus.step, 0);
      cyc_begin(); cmd_none(); cyc_sample();
      check("done_hold", bus.done, 1);

      // clear wins over start from DONE
      cyc_begin(); bus.clear = 1'b1; bus.start = 1'b1; cyc_sample();
      cyc_begin(); cmd_none(); cyc_sample();
      check("clr_cnt_clr", bus.cnt_clr, 1);
      check("clr_done", bus.done, 0);
      check("clr_busy", bus.busy, 0);
      cyc_begin(); cyc_sample();
      check("clr_idle_cnt_clr", bus.cnt_clr, 0);
      check("clr_count", cnt, 0);
      check("clr_idle_busy", bus.busy, 0);

      // Pause with the phase frozen at 2, then resume.
      cyc_begin(); bus.limit = 8'd20; bus.start = 1'b1;
      pulses = 0;
      for (int c = 0; c < 14; c++) begin
         cyc_begin(); cmd_none();
         if (c >= 1 && c <= 10) bus.stop = 1'b1;
         if (c == 11) bus.start = 1'b1;
         cyc_sample();
         if (c >= 2 && c <= 11) pulses += int'(bus.step);
         if (c == 6) check("pause_busy", bus.busy, 0);
         if (c == 12) begin
            check("resume_step12", bus.step, 0);
            check("resume_busy12", bus.busy, 1);
         end
         if (c == 13) check("resume_step13", bus.step, 1);
      end
      check("pause_steps", pulses, 0);

      cyc_begin(); bus.clear = 1'b1; cyc_sample();
      cyc_begin(); cmd_none(); cyc_sample();
      cyc_begin(); cyc_sample();

      // Held single level in IDLE
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         cyc_begin(); cmd_none();
         if (c < 10) bus.single = 1'b1;
         cyc_sample();
         pulses += int'(bus.step);
         if (c == 0) check("single_first", bus.step, 1);
      end
      check("single_pulses", pulses, 1);
      check("single_count", cnt, 1);
      cyc_begin(); cmd_none(); ld = 1'b1; ld_val = 8'd20; cyc_sample();
      cyc_begin(); cmd_none(); bus.single = 1'b1; cyc_sample();
      check("single_at_limit", bus.step, 0);
      check("single_limit_count", cnt, 20);
      cyc_begin(); cmd_none(); cyc_sample();

      // Wrap from 250 through 255 -> 0 to limit 3
      cyc_begin(); cmd_none(); ld = 1'b1; ld_val = 8'd250; bus.limit = 8'd3; cyc_sample();
      cyc_begin(); cmd_none(); bus.start = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         cyc_begin(); cmd_none(); cyc_sample();
         pulses += int'(bus.step);
         if (c == 24) check("wrap_zero", cnt, 0);
         if (c == 36) begin
            check("wrap_count36", cnt, 3);
            check("wrap_done36", bus.done, 0);
         end
         if (c == 37) check("wrap_done37", bus.done, 1);
      end
      check("wrap_pulses", pulses, 9);

      // Async reset in the middle of a step cycle
      cyc_begin(); bus.clear = 1'b1; cyc_sample();
      cyc_begin(); cmd_none(); cyc_sample();
      cyc_begin(); ld = 1'b1; ld_val = 8'd0; bus.limit = 8'd50; cyc_sample();
      cyc_begin(); cmd_none(); bus.start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         cyc_begin(); cmd_none(); cyc_sample();
      end
      cyc_begin(); cmd_none();
      #1;
      check("prerst_step", bus.step, 1);
      check("prerst_busy", bus.busy, 1);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_step", bus.step, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_cnt_clr", bus.cnt_clr, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc_begin(); cyc_sample();
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_cnt_clr", bus.cnt_clr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
